// File: rtl/led_top.sv
// Rotating one-hot LED chaser with button hold and an optional JTAG TAP whose
// LEDCTRL register can override the LEDs; the TAP is compiled in with LED_TOP_JTAG_EN.
module led_top #(
    parameter int          DIV_LOG2 = 6,
    parameter logic [31:0] IDCODE   = 32'h1000_0A6D
) (
    input  logic clk,
    input  logic reset,
    input  logic jtag_tck,
    input  logic jtag_tms,
    input  logic jtag_tdi,
    output logic jtag_tdo,
    output logic led0,
    output logic led1,
    output logic led2,
    input  logic button
);

    logic                button_meta;
    logic                held;
    logic [DIV_LOG2-1:0] presc;
    logic [2:0]          pattern;
    logic                tick;

    assign tick = &presc;

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            button_meta <= 1'b0;
            held        <= 1'b0;
            presc       <= '0;
            pattern     <= 3'b001;
        end else begin
            button_meta <= button;
            held        <= button_meta;
            presc       <= presc + 1'b1;
            if (tick && !held)
                pattern <= {pattern[1:0], pattern[2]};
        end
    end

`ifdef LED_TOP_JTAG_EN
    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_t;

    localparam logic [3:0] INSTR_IDCODE  = 4'b0001;
    localparam logic [3:0] INSTR_LEDCTRL = 4'b0010;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        case (s)
            TLR:     tap_next = tms ? TLR    : RTI;
            RTI:     tap_next = tms ? SEL_DR : RTI;
            SEL_DR:  tap_next = tms ? SEL_IR : CAP_DR;
            CAP_DR:  tap_next = tms ? EX1_DR : SH_DR;
            SH_DR:   tap_next = tms ? EX1_DR : SH_DR;
            EX1_DR:  tap_next = tms ? UPD_DR : PAU_DR;
            PAU_DR:  tap_next = tms ? EX2_DR : PAU_DR;
            EX2_DR:  tap_next = tms ? UPD_DR : SH_DR;
            UPD_DR:  tap_next = tms ? SEL_DR : RTI;
            SEL_IR:  tap_next = tms ? TLR    : CAP_IR;
            CAP_IR:  tap_next = tms ? EX1_IR : SH_IR;
            SH_IR:   tap_next = tms ? EX1_IR : SH_IR;
            EX1_IR:  tap_next = tms ? UPD_IR : PAU_IR;
            PAU_IR:  tap_next = tms ? EX2_IR : PAU_IR;
            EX2_IR:  tap_next = tms ? UPD_IR : SH_IR;
            UPD_IR:  tap_next = tms ? SEL_DR : RTI;
            default: tap_next = TLR;
        endcase
    endfunction

    logic [1:0]  tck_sync, tms_sync, tdi_sync;
    logic        tck_d;
    logic        tck_rise, tck_fall;
    tap_state_t  tap;
    logic [3:0]  ir, ir_sr;
    logic [31:0] dr_sr;
    logic [3:0]  ledctrl;
    logic        tdo_q;

    assign tck_rise = tck_sync[1] & ~tck_d;
    assign tck_fall = ~tck_sync[1] & tck_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_d    <= 1'b0;
            tap      <= TLR;
            ir       <= INSTR_IDCODE;
            ir_sr    <= '0;
            dr_sr    <= '0;
            ledctrl  <= '0;
            tdo_q    <= 1'b0;
        end else begin
            tck_sync <= {tck_sync[0], jtag_tck};
            tms_sync <= {tms_sync[0], jtag_tms};
            tdi_sync <= {tdi_sync[0], jtag_tdi};
            tck_d    <= tck_sync[1];

            // Register actions belong to the state being left on this rise.
            if (tck_rise) begin
                tap <= tap_next(tap, tms_sync[1]);
                case (tap)
                    CAP_IR: ir_sr <= 4'b0101;
                    SH_IR:  ir_sr <= {tdi_sync[1], ir_sr[3:1]};
                    UPD_IR: ir    <= ir_sr;
                    CAP_DR: begin
                        case (ir)
                            INSTR_IDCODE:  dr_sr <= IDCODE;
                            INSTR_LEDCTRL: dr_sr <= {28'd0, ledctrl};
                            default:       dr_sr <= '0;
                        endcase
                    end
                    SH_DR: begin
                        case (ir)
                            INSTR_IDCODE:  dr_sr      <= {tdi_sync[1], dr_sr[31:1]};
                            INSTR_LEDCTRL: dr_sr[3:0] <= {tdi_sync[1], dr_sr[3:1]};
                            default:       dr_sr[0]   <= tdi_sync[1];
                        endcase
                    end
                    UPD_DR: if (ir == INSTR_LEDCTRL) ledctrl <= dr_sr[3:0];
                    default: ;
                endcase
            end

            if (tck_fall) begin
                if (tap == SH_IR)
                    tdo_q <= ir_sr[0];
                else if (tap == SH_DR)
                    tdo_q <= dr_sr[0];
                else
                    tdo_q <= 1'b0;
            end

            // Sitting in Test-Logic-Reset wins over any update above.
            if (tap == TLR) begin
                ir      <= INSTR_IDCODE;
                ledctrl <= '0;
            end
        end
    end

    assign jtag_tdo = tdo_q;
    assign {led2, led1, led0} = ledctrl[3] ? ledctrl[2:0] : pattern;
`else
    logic unused_jtag;
    assign unused_jtag = ^{jtag_tck, jtag_tms, jtag_tdi, IDCODE};
    assign jtag_tdo = 1'b0;
    assign {led2, led1, led0} = pattern;
`endif

endmodule

// File: tb/tb_led_top.sv
// Directed bench for led_top: LED stepping, button hold and, when
// LED_TOP_JTAG_EN is defined, IDCODE / LEDCTRL / BYPASS access over JTAG.
module tb_led_top;

    localparam logic [31:0] IDC = 32'h1000_0A6D;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic jtag_tck = 1'b0;
    logic jtag_tms = 1'b0;
    logic jtag_tdi = 1'b0;
    logic button = 1'b0;
    logic jtag_tdo;
    logic led0, led1, led2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    led_top #(.DIV_LOG2(6), .IDCODE(IDC)) dut (
        .clk      (clk),
        .reset    (reset),
        .jtag_tck (jtag_tck),
        .jtag_tms (jtag_tms),
        .jtag_tdi (jtag_tdi),
        .jtag_tdo (jtag_tdo),
        .led0     (led0),
        .led1     (led1),
        .led2     (led2),
        .button   (button)
    );

    always #5 clk = ~clk;

    // Cycles elapsed since the last reset release; drives the pattern model.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [2:0] model_leds(input int c);
        case ((c / 64) % 3)
            0:       model_leds = 3'b001;
            1:       model_leds = 3'b010;
            default: model_leds = 3'b100;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        cycles(n);
        reset = 1'b0;
    endtask

    task automatic tck_cycle(input logic tms, input logic tdi);
        @(negedge clk);
        jtag_tms = tms;
        jtag_tdi = tdi;
        cycles(6);
        jtag_tck = 1'b1;
        cycles(6);
        jtag_tck = 1'b0;
        cycles(6);
    endtask

`ifdef LED_TOP_JTAG_EN
    // From Run-Test/Idle: load an IR value, checking the captured 0101, back to idle.
    task automatic load_ir(input logic [3:0] v);
        logic [3:0] cap;
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cap[i] = jtag_tdo;
            tck_cycle(i == 3, v[i]);
        end
        check("ir_capture", {28'd0, cap}, 32'h5);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    // From Run-Test/Idle: shift n DR bits LSB first, collect tdo, update, back to idle.
    task automatic shift_dr(input logic [31:0] v, input int n, output logic [31:0] bits);
        bits = '0;
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            bits[i] = jtag_tdo;
            tck_cycle(i == n - 1, v[i]);
        end
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask
`endif

    initial begin
        logic [31:0] bits;
        bits = '0;

        // Free-running pattern after a 4-cycle reset.
        do_reset(4);
        check("reset_leds", {29'd0, led2, led1, led0}, 32'h1);
        check("reset_tdo", {31'd0, jtag_tdo}, 32'h0);
        cycles(63);
        check("cyc63_leds", {29'd0, led2, led1, led0}, 32'h1);
        cycles(1);
        check("cyc64_leds", {29'd0, led2, led1, led0}, 32'h2);
        cycles(64);
        check("cyc128_leds", {29'd0, led2, led1, led0}, 32'h4);
        cycles(64);
        check("cyc192_leds", {29'd0, led2, led1, led0}, 32'h1);

        // Button held from cycle 50 to 200 suppresses steps at 64/128/192.
        do_reset(4);
        cycles(50);
        button = 1'b1;
        cycles(14);
        check("hold_cyc64", {29'd0, led2, led1, led0}, 32'h1);
        cycles(128);
        check("hold_cyc192", {29'd0, led2, led1, led0}, 32'h1);
        cycles(8);
        button = 1'b0;
        cycles(55);
        check("hold_cyc255", {29'd0, led2, led1, led0}, 32'h1);
        cycles(1);
        check("hold_cyc256", {29'd0, led2, led1, led0}, 32'h2);
        cycles(64);
        check("hold_cyc320", {29'd0, led2, led1, led0}, 32'h4);

`ifdef LED_TOP_JTAG_EN
        // IDCODE readout after forcing Test-Logic-Reset.
        do_reset(4);
        repeat (5) tck_cycle(1'b1, 1'b0);
        check("tlr_tdo", {31'd0, jtag_tdo}, 32'h0);
        tck_cycle(1'b0, 1'b0);
        shift_dr(32'h0, 32, bits);
        check("idcode", bits, IDC);

        // LEDCTRL override to 101, held across pattern ticks.
        load_ir(4'b0010);
        shift_dr(32'hD, 4, bits);
        check("ovr_on", {29'd0, led2, led1, led0}, 32'h5);
        cycles(150);
        check("ovr_hold", {29'd0, led2, led1, led0}, 32'h5);
        shift_dr(32'h0, 4, bits);
        check("ledctrl_capture", {28'd0, bits[3:0]}, 32'hD);
        check("ovr_off", {29'd0, led2, led1, led0}, {29'd0, model_leds(cyc)});

        // BYPASS: captured 0, then tdi delayed by one TCK.
        load_ir(4'b1111);
        shift_dr(32'h5, 3, bits);
        check("bypass", {29'd0, bits[2:0]}, 32'h2);

        // Reset in the middle of a Shift-DR with the override active.
        load_ir(4'b0010);
        shift_dr(32'hD, 4, bits);
        check("ovr_again", {29'd0, led2, led1, led0}, 32'h5);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b1);
        do_reset(2);
        check("abort_leds", {29'd0, led2, led1, led0}, 32'h1);
        check("abort_tdo", {31'd0, jtag_tdo}, 32'h0);
        tck_cycle(1'b0, 1'b0);
        shift_dr(32'h0, 32, bits);
        check("abort_idcode", bits, IDC);
        check("abort_pattern", {29'd0, led2, led1, led0}, {29'd0, model_leds(cyc)});
`else
        // Without the TAP, JTAG activity must leave tdo low and the LEDs untouched.
        do_reset(4);
        repeat (5) tck_cycle(1'b1, 1'b1);
        check("nojtag_tlr_tdo", {31'd0, jtag_tdo}, 32'h0);
        tck_cycle(1'b0, 1'b1);
        tck_cycle(1'b1, 1'b1);
        tck_cycle(1'b0, 1'b1);
        tck_cycle(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("nojtag_shift_tdo", {31'd0, jtag_tdo}, 32'h0);
            tck_cycle(1'b0, i[0]);
        end
        check("nojtag_leds", {29'd0, led2, led1, led0}, {29'd0, model_leds(cyc)});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_top.md
LED_TOP -- requirements
Module: led_top

Interface
REQ-001 Parameter DIV_LOG2, default 6: LED step period is 2^DIV_LOG2 clk cycles.
REQ-002 Parameter IDCODE, default 32'h1000_0A6D: JTAG IDCODE value; bit 0 SHALL be 1.
REQ-003 Port clk, input, 1: single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port reset, input, 1: reset is synchronous and active-high.
REQ-005 Port jtag_tck, input, 1: JTAG test clock, asynchronous to clk, oversampled.
REQ-006 Port jtag_tms, input, 1: JTAG mode select.
REQ-007 Port jtag_tdi, input, 1: JTAG serial data in.
REQ-008 Port jtag_tdo, output, 1: JTAG serial data out; 0 outside Shift-IR/Shift-DR.
REQ-009 Port led0/led1/led2, output, 1 each: LED drives, active-high.
REQ-010 Port button, input, 1: hold request, active-high; the bench SHALL drive it.

Function
REQ-011 button SHALL pass through a 2-flop synchronizer; "held" is the synchronized value.
REQ-012 A DIV_LOG2-bit prescaler SHALL increment every cycle and wrap; a tick occurs on the cycle it equals all-ones.
REQ-013 Pattern register {led2,led1,led0} SHALL rotate left one-hot (001->010->100->001) on each tick where held=0, otherwise hold.
REQ-014 The prescaler SHALL keep counting while held; a hold only suppresses steps.
REQ-015 jtag_tck/tms/tdi SHALL each use a 2-flop synchronizer; a synced tck 0->1 SHALL be a TCK-rise event, 1->0 a TCK-fall event; tck high and low phases SHALL each be at least 4 clk cycles.
REQ-016 On each TCK-rise, the 16-state IEEE 1149.1 TAP controller SHALL advance on synced tms; five consecutive tms=1 rises SHALL reach Test-Logic-Reset.
REQ-017 Instruction register: 4 bits; Capture-IR loads 4'b0101; Update-IR latches shifted value; Test-Logic-Reset selects IDCODE.
REQ-018 Instructions: 4'b0001 IDCODE (32-bit, Capture-DR loads IDCODE); 4'b0010 LEDCTRL (4-bit); any other code selects 1-bit BYPASS (Capture-DR loads 0).
REQ-019 Shift-IR/Shift-DR SHALL shift LSB first, tdi entering at MSB, on TCK-rise.
REQ-020 jtag_tdo SHALL update on TCK-fall to the LSB of the active shift register in Shift-IR/Shift-DR, else 0.
REQ-021 LEDCTRL register {ovr,val[2:0]}: Capture-DR loads current contents; Update-DR latches shifted value.
REQ-022 LED outputs SHALL equal val when ovr=1, else the pattern register; the pattern keeps running underneath.
REQ-023 Test-Logic-Reset entry SHALL clear LEDCTRL to 0.

Reset
REQ-024 On reset=1 at a clk edge: pattern=001 (led0=1, led1=0, led2=0), prescaler=0, synchronizers=0, TAP=Test-Logic-Reset, IR=IDCODE, LEDCTRL=0, jtag_tdo=0.
REQ-025 Reset asserted mid-JTAG-shift or mid-hold SHALL abort the operation and restore REQ-024 values on the next edge.
REQ-026 First pattern step SHALL occur 2^DIV_LOG2 cycles after the first cycle with reset=0 (button=0).

Configuration
REQ-027 Macro LED_TOP_JTAG_EN defined: JTAG TAP and LEDCTRL override compiled in per REQ-015..REQ-023.
REQ-028 Macro LED_TOP_JTAG_EN undefined: JTAG logic omitted, jtag inputs ignored, jtag_tdo tied 0, LEDs always show the pattern.

Verification
REQ-029 Reset 4 cycles, jtag inputs 0, button=0, DIV_LOG2=6 -> LEDs 001; at cycle 64 after release LEDs 010, at 128 LEDs 100, at 192 LEDs 001.
REQ-030 button=1 from cycle 50 to 200 -> LEDs remain 001 until the first tick after button sync clears (cycle 256), then 010.
REQ-031 5 TMS=1 rises, go to Shift-DR, shift 32 bits -> jtag_tdo sequence equals IDCODE LSB first (bit 0 = 1).
REQ-032 Load IR 4'b0010, shift DR 4'b1101 and Update-DR -> LEDs 101 and hold regardless of pattern ticks; shifting 4'b0000 -> pattern visible again.
REQ-033 IR 4'b1111, shift 1,0,1 in Shift-DR -> jtag_tdo sees 0 (captured), 1, 0 delayed one TCK (BYPASS).
REQ-034 Assert reset during Shift-DR with override active -> LEDs return to 001, LEDCTRL=0, TAP in Test-Logic-Reset, jtag_tdo=0.
